// File: rtl/hazard_controller_pkg.sv
// rtl/hazard_controller_pkg.sv - shared pipeline hazard types and constants
package hazard_controller_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_t;

endpackage

// File: rtl/hazard_controller_forward_unit.sv
// rtl/hazard_controller_forward_unit.sv - per-operand forwarding select, MEM before WB
module forward_unit
  import hazard_controller_pkg::*;
(
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rd_mem,
  input  logic [REG_W-1:0] rd_wb,
  input  logic             reg_wrt_mem,
  input  logic             reg_wrt_wb,
  output logic [1:0]       fwd_sel
);

  // x0 is hardwired zero, so a write to it never produces a forwardable value
  always_comb begin
    fwd_sel = FWD_RF;
    if (reg_wrt_mem && (rd_mem != '0) && (rd_mem == rs)) begin
      fwd_sel = FWD_MEM;
    end else if (reg_wrt_wb && (rd_wb != '0) && (rd_wb == rs)) begin
      fwd_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - pipeline stall/flush/forward control with memory-wait tracking
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int WAIT_LIMIT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] Rs1D,
  input  logic [REG_W-1:0] Rs2D,
  input  logic [REG_W-1:0] Rs1E,
  input  logic [REG_W-1:0] Rs2E,
  input  logic [REG_W-1:0] RDEx,
  input  logic [REG_W-1:0] RD_Mem,
  input  logic [REG_W-1:0] RD_Wb,
  input  logic             RegWrtEx,
  input  logic             RegWrtMem,
  input  logic             RegWrtWb,
  input  logic             ResultSrcEx,
  input  logic             PCSrcEx,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic [1:0]       ForwardA_Ex,
  output logic [1:0]       ForwardB_Ex,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             mem_timeout,
  output logic [15:0]      stall_cnt,
  output logic [15:0]      flush_cnt
);

  hz_state_t  state;
  logic [8:0] wait_cnt;
  logic [8:0] wait_inc;
  logic       freeze;
  logic       branch;
  logic       load_use;

  forward_unit u_fwd_a (
    .rs          (Rs1E),
    .rd_mem      (RD_Mem),
    .rd_wb       (RD_Wb),
    .reg_wrt_mem (RegWrtMem),
    .reg_wrt_wb  (RegWrtWb),
    .fwd_sel     (ForwardA_Ex)
  );

  forward_unit u_fwd_b (
    .rs          (Rs2E),
    .rd_mem      (RD_Mem),
    .rd_wb       (RD_Wb),
    .reg_wrt_mem (RegWrtMem),
    .reg_wrt_wb  (RegWrtWb),
    .fwd_sel     (ForwardB_Ex)
  );

  // Freeze outranks a taken branch, which outranks a load-use bubble
  assign freeze   = dmem_req & ~dmem_ready;
  assign branch   = ~freeze & PCSrcEx;
  assign load_use = ~freeze & ~PCSrcEx & ResultSrcEx & RegWrtEx & (RDEx != '0)
                  & ((RDEx == Rs1D) | (RDEx == Rs2D));

  assign StallF = rst & (freeze | load_use);
  assign StallD = rst & (freeze | load_use);
  assign StallE = rst & freeze;
  assign StallM = rst & freeze;
  assign FlushD = rst & branch;
  assign FlushE = rst & (branch | load_use);

  assign wait_inc = (wait_cnt == 9'h1FF) ? wait_cnt : wait_cnt + 9'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      case (state)
        RUN: begin
          if (freeze) begin
            state    <= MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          wait_cnt <= wait_inc;
          if (int'(wait_inc) >= WAIT_LIMIT) begin
            mem_timeout <= 1'b1;
          end
          if (!freeze) begin
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase

      if (StallF && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
      if (FlushD && (flush_cnt != 16'hFFFF)) begin
        flush_cnt <= flush_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - directed scoreboard bench for hazard_controller
module tb_hazard_controller;
  import hazard_controller_pkg::*;

  logic        clk;
  logic        rst;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RDEx, RD_Mem, RD_Wb;
  logic        RegWrtEx, RegWrtMem, RegWrtWb, ResultSrcEx, PCSrcEx;
  logic        dmem_req, dmem_ready;
  logic [1:0]  ForwardA_Ex, ForwardB_Ex;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE;
  logic        mem_timeout;
  logic [15:0] stall_cnt, flush_cnt;

  logic [31:0] exp_q[$];
  string       tag_q[$];
  int          total = 0;
  int          bad = 0;
  int          sc = 0;
  int          fc = 0;

  hazard_controller #(.WAIT_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RDEx(RDEx), .RD_Mem(RD_Mem), .RD_Wb(RD_Wb),
    .RegWrtEx(RegWrtEx), .RegWrtMem(RegWrtMem), .RegWrtWb(RegWrtWb),
    .ResultSrcEx(ResultSrcEx), .PCSrcEx(PCSrcEx),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .ForwardA_Ex(ForwardA_Ex), .ForwardB_Ex(ForwardB_Ex),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ctl();
    return {26'd0, StallF, StallD, StallE, StallM, FlushD, FlushE};
  endfunction

  task automatic push(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%0h required=entry", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s observed=%0h required=%0h", t, obs, e);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    {Rs1D, Rs2D, Rs1E, Rs2E, RDEx, RD_Mem, RD_Wb} = '0;
    {RegWrtEx, RegWrtMem, RegWrtWb, ResultSrcEx, PCSrcEx} = '0;
    dmem_req = 1'b0;
    dmem_ready = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    #1 rst = 1'b0;
    // outputs held low in reset even with a freeze request
    dmem_req = 1'b1;
    push("reset_ctl", 32'h0);
    push("reset_stall_cnt", 32'h0);
    push("reset_flush_cnt", 32'h0);
    push("reset_timeout", 32'h0);
    #1;
    pop_check(ctl());
    pop_check({16'd0, stall_cnt});
    pop_check({16'd0, flush_cnt});
    pop_check({31'd0, mem_timeout});
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;

    // forwarding
    RegWrtMem = 1'b1; RD_Mem = 5'd5; RegWrtWb = 1'b1; RD_Wb = 5'd5; Rs1E = 5'd5; Rs2E = 5'd0;
    push("fwd_a_mem", 32'(FWD_MEM));
    push("fwd_b_rf", 32'(FWD_RF));
    #1;
    pop_check({30'd0, ForwardA_Ex});
    pop_check({30'd0, ForwardB_Ex});
    RD_Mem = 5'd0;
    push("fwd_a_wb", 32'(FWD_WB));
    #1 pop_check({30'd0, ForwardA_Ex});
    RD_Mem = 5'd9; Rs2E = 5'd9; RegWrtWb = 1'b0;
    push("fwd_b_mem", 32'(FWD_MEM));
    push("fwd_a_nowb", 32'(FWD_RF));
    #1;
    pop_check({30'd0, ForwardB_Ex});
    pop_check({30'd0, ForwardA_Ex});
    @(negedge clk);
    clear_inputs();

    // load-use
    ResultSrcEx = 1'b1; RegWrtEx = 1'b1; RDEx = 5'd7; Rs2D = 5'd7;
    push("loaduse_ctl", 32'b110001);
    #1 pop_check(ctl());
    step();
    clear_inputs();
    sc++;
    push("loaduse_stall_cnt", 32'(sc));
    push("idle_ctl", 32'h0);
    #1;
    pop_check({16'd0, stall_cnt});
    pop_check(ctl());
    ResultSrcEx = 1'b1; RegWrtEx = 1'b1; RDEx = 5'd0; Rs1D = 5'd0;
    push("loaduse_x0_ctl", 32'h0);
    #1 pop_check(ctl());
    @(negedge clk);
    clear_inputs();

    // branch
    PCSrcEx = 1'b1;
    push("branch_ctl", 32'b000011);
    #1 pop_check(ctl());
    step();
    clear_inputs();
    fc++;
    push("branch_flush_cnt", 32'(fc));
    #1 pop_check({16'd0, flush_cnt});

    // memory wait, 4 cycles
    @(negedge clk);
    dmem_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push("memwait_ctl", 32'b111100);
      #1 pop_check(ctl());
      step();
      if (i == 0) begin
        push("memwait_state", 32'(MEM_WAIT));
        pop_check(32'(dut.state));
      end
    end
    dmem_ready = 1'b1;
    push("memwait_exit_ctl", 32'h0);
    #1 pop_check(ctl());
    step();
    clear_inputs();
    sc += 4;
    push("memwait_state_run", 32'(RUN));
    push("memwait_stall_cnt", 32'(sc));
    #1;
    pop_check(32'(dut.state));
    pop_check({16'd0, stall_cnt});

    // branch held through a freeze flushes only after it, counted once
    @(negedge clk);
    dmem_req = 1'b1; PCSrcEx = 1'b1;
    for (int i = 0; i < 2; i++) begin
      push("frz_branch_ctl", 32'b111100);
      #1 pop_check(ctl());
      step();
    end
    dmem_ready = 1'b1;
    push("frz_branch_exit_ctl", 32'b000011);
    #1 pop_check(ctl());
    step();
    clear_inputs();
    sc += 2;
    fc++;
    push("frz_branch_flush_cnt", 32'(fc));
    push("frz_branch_stall_cnt", 32'(sc));
    #1;
    pop_check({16'd0, flush_cnt});
    pop_check({16'd0, stall_cnt});

    // timeout with WAIT_LIMIT=8
    @(negedge clk);
    dmem_req = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      push("timeout_ctl", 32'b111100);
      #1 pop_check(ctl());
      step();
      if (i == 8) begin
        push("timeout_before", 32'h0);
        pop_check({31'd0, mem_timeout});
      end
      if (i == 9) begin
        push("timeout_set", 32'h1);
        pop_check({31'd0, mem_timeout});
      end
    end
    dmem_ready = 1'b1;
    step();
    clear_inputs();
    sc += 10;
    step();
    push("timeout_sticky", 32'h1);
    push("timeout_state_run", 32'(RUN));
    push("timeout_stall_cnt", 32'(sc));
    pop_check({31'd0, mem_timeout});
    pop_check(32'(dut.state));
    pop_check({16'd0, stall_cnt});

    // reset during the third MEM_WAIT cycle
    dmem_req = 1'b1; PCSrcEx = 1'b1;
    RegWrtMem = 1'b1; RD_Mem = 5'd3; Rs1E = 5'd3;
    step();
    step();
    step();
    push("midwait_state", 32'(MEM_WAIT));
    pop_check(32'(dut.state));
    #2 rst = 1'b0;
    push("rstwait_ctl", 32'h0);
    push("rstwait_state", 32'(RUN));
    push("rstwait_stall_cnt", 32'h0);
    push("rstwait_flush_cnt", 32'h0);
    push("rstwait_timeout", 32'h0);
    push("rstwait_wait_cnt", 32'h0);
    push("rstwait_fwd_a", 32'(FWD_MEM));
    #1;
    pop_check(ctl());
    pop_check(32'(dut.state));
    pop_check({16'd0, stall_cnt});
    pop_check({16'd0, flush_cnt});
    pop_check({31'd0, mem_timeout});
    pop_check({23'd0, dut.wait_cnt});
    pop_check({30'd0, ForwardA_Ex});
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
